// File: rtl/hpi_responder_model_pkg.sv
// Shared types for the HPI responder model: register selects, FSM states,
// STATUS bit positions and a helper that assembles the STATUS word.
package hpi_pkg;

    typedef enum logic [1:0] {
        HPI_DATA = 2'b00,
        HPI_MBX  = 2'b01,
        HPI_ADDR = 2'b10,
        HPI_STAT = 2'b11
    } hpi_reg_e;

    typedef enum logic [1:0] {
        IDLE,
        RD_ACT,
        WR_ACT
    } hpi_st_e;

    localparam int STAT_INT_BIT   = 0;
    localparam int STAT_MBXIN_BIT = 1;
    localparam int STAT_ERR_BIT   = 15;

    localparam logic [15:0] ADDR_STEP = 16'd2;

    function automatic logic [15:0] status_word(input logic err,
                                                input logic mbx_in_pending,
                                                input logic irq);
        logic [15:0] w;
        w                 = '0;
        w[STAT_ERR_BIT]   = err;
        w[STAT_MBXIN_BIT] = mbx_in_pending;
        w[STAT_INT_BIT]   = irq;
        return w;
    endfunction

endpackage

// File: rtl/hpi_responder_model_if.sv
// HPI strobe/select bundle between the host-side driver and the responder.
// The 16-bit data bus stays a plain inout on the responder.
interface hpi_if;

    logic [1:0] OTG_ADDR;
    logic       OTG_RD_N;
    logic       OTG_WR_N;
    logic       OTG_CS_N;
    logic       OTG_RST_N;
    logic       OTG_INT;

    modport master (
        output OTG_ADDR, OTG_RD_N, OTG_WR_N, OTG_CS_N, OTG_RST_N,
        input  OTG_INT
    );

    modport slave (
        input  OTG_ADDR, OTG_RD_N, OTG_WR_N, OTG_CS_N, OTG_RST_N,
        output OTG_INT
    );

endinterface

// File: rtl/hpi_responder_model_ram.sv
// True dual-port RAM with synchronous reads; port A (host) wins when both
// ports write the same word in one cycle. Reads during a write return old data.
module hpi_dp_ram
    import hpi_pkg::*;
#(
    parameter  int MEM_WORDS = 4096,
    localparam int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] a_addr,
    input  logic          a_we,
    input  logic [15:0]   a_wdata,
    output logic [15:0]   a_rdata,
    input  logic [AW-1:0] b_addr,
    input  logic          b_we,
    input  logic [15:0]   b_wdata,
    output logic [15:0]   b_rdata
);

    logic [15:0] mem [MEM_WORDS];
    logic [15:0] a_rdata_q;
    logic [15:0] b_rdata_q;
    logic        b_we_eff;

    assign b_we_eff = b_we && !(a_we && (a_addr == b_addr));

    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr] <= a_wdata;
        end
        if (b_we_eff) begin
            mem[b_addr] <= b_wdata;
        end
        a_rdata_q <= mem[a_addr];
        b_rdata_q <= mem[b_addr];
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: rtl/hpi_responder_model.sv
// Device end of the EZ-OTG HPI bus: decodes host strobes, owns DATA/MAILBOX/
// ADDRESS/STATUS and backs DATA with a dual-port RAM shared with device logic.
module hpi_responder_model
    import hpi_pkg::*;
#(
    parameter  int MEM_WORDS = 4096,
    localparam int AW        = $clog2(MEM_WORDS)
) (
    input  logic          Clk,
    input  logic          Reset,
    inout  wire  [15:0]   OTG_DATA,
    hpi_if.slave          hpi,
    input  logic [AW-1:0] dev_addr,
    input  logic [15:0]   dev_wdata,
    input  logic          dev_we,
    output logic [15:0]   dev_rdata,
    input  logic          dev_mbx_out_wr,
    input  logic [15:0]   dev_mbx_out_data,
    output logic          dev_mbx_in_valid,
    output logic [15:0]   dev_mbx_in_data,
    input  logic          dev_mbx_in_ack,
    output logic          proto_err
);

    hpi_st_e     state_q, state_d;
    hpi_reg_e    reg_sel_q, reg_sel_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] rd_hold_q, rd_hold_d;
    logic [15:0] wr_hold_q, wr_hold_d;
    logic [15:0] mbx_in_q, mbx_in_d;
    logic        mbx_in_valid_q, mbx_in_valid_d;
    logic [15:0] mbx_out_q, mbx_out_d;
    logic        int_q, int_d;
    logic        proto_err_q, proto_err_d;

    logic          clear;
    logic          rd_low;
    logic          wr_low;
    logic          both_low;
    logic          ram_we;
    logic [15:0]   ram_a_rdata;
    logic [AW-1:0] host_idx;
    logic [15:0]   rd_value;

    assign clear    = !Reset || !hpi.OTG_RST_N;
    assign rd_low   = !hpi.OTG_CS_N && !hpi.OTG_RD_N;
    assign wr_low   = !hpi.OTG_CS_N && !hpi.OTG_WR_N;
    assign both_low = rd_low && wr_low;
    assign host_idx = addr_q[AW:1];

    hpi_dp_ram #(.MEM_WORDS(MEM_WORDS)) u_ram (
        .clk     (Clk),
        .a_addr  (host_idx),
        .a_we    (ram_we),
        .a_wdata (wr_hold_q),
        .a_rdata (ram_a_rdata),
        .b_addr  (dev_addr),
        .b_we    (dev_we),
        .b_wdata (dev_wdata),
        .b_rdata (dev_rdata)
    );

    // Value presented for a read that starts this cycle, chosen by the live select.
    always_comb begin
        rd_value = ram_a_rdata;
        case (hpi_reg_e'(hpi.OTG_ADDR))
            HPI_MBX:  rd_value = mbx_out_q;
            HPI_ADDR: rd_value = addr_q;
            HPI_STAT: rd_value = status_word(proto_err_q, mbx_in_valid_q, int_q);
            default:  rd_value = ram_a_rdata;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        reg_sel_d      = reg_sel_q;
        addr_d         = addr_q;
        rd_hold_d      = rd_hold_q;
        wr_hold_d      = wr_hold_q;
        mbx_in_d       = mbx_in_q;
        mbx_in_valid_d = dev_mbx_in_ack ? 1'b0 : mbx_in_valid_q;
        mbx_out_d      = mbx_out_q;
        int_d          = int_q;
        proto_err_d    = proto_err_q;
        ram_we         = 1'b0;

        case (state_q)
            IDLE: begin
                if (both_low) begin
                    proto_err_d = 1'b1;
                end else if (rd_low) begin
                    state_d   = RD_ACT;
                    reg_sel_d = hpi_reg_e'(hpi.OTG_ADDR);
                    rd_hold_d = rd_value;
                end else if (wr_low) begin
                    state_d   = WR_ACT;
                    reg_sel_d = hpi_reg_e'(hpi.OTG_ADDR);
                    wr_hold_d = OTG_DATA;
                end
            end
            RD_ACT: begin
                if (both_low) begin
                    proto_err_d = 1'b1;
                    state_d     = IDLE;
                end else if (!rd_low) begin
                    state_d = IDLE;
                    if (reg_sel_q == HPI_DATA) begin
                        addr_d = addr_q + ADDR_STEP;
                    end else if (reg_sel_q == HPI_MBX) begin
                        int_d = 1'b0;
                    end
                end
            end
            WR_ACT: begin
                if (both_low) begin
                    proto_err_d = 1'b1;
                    state_d     = IDLE;
                end else if (!wr_low) begin
                    state_d = IDLE;
                    case (reg_sel_q)
                        HPI_DATA: begin
                            ram_we = 1'b1;
                            addr_d = addr_q + ADDR_STEP;
                        end
                        HPI_ADDR: addr_d = wr_hold_q & 16'hFFFE;
                        HPI_MBX: begin
                            mbx_in_d       = wr_hold_q;
                            mbx_in_valid_d = 1'b1;
                        end
                        default: ;
                    endcase
                end else begin
                    wr_hold_d = OTG_DATA;
                end
            end
            default: state_d = IDLE;
        endcase

        // A device post overrides the interrupt clear of a coincident host mailbox read.
        if (dev_mbx_out_wr) begin
            mbx_out_d = dev_mbx_out_data;
            int_d     = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (clear) begin
            state_q        <= IDLE;
            reg_sel_q      <= HPI_DATA;
            addr_q         <= '0;
            rd_hold_q      <= '0;
            wr_hold_q      <= '0;
            mbx_in_q       <= '0;
            mbx_in_valid_q <= 1'b0;
            mbx_out_q      <= '0;
            int_q          <= 1'b0;
            proto_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            reg_sel_q      <= reg_sel_d;
            addr_q         <= addr_d;
            rd_hold_q      <= rd_hold_d;
            wr_hold_q      <= wr_hold_d;
            mbx_in_q       <= mbx_in_d;
            mbx_in_valid_q <= mbx_in_valid_d;
            mbx_out_q      <= mbx_out_d;
            int_q          <= int_d;
            proto_err_q    <= proto_err_d;
        end
    end

    assign OTG_DATA = (state_q == RD_ACT && rd_low && hpi.OTG_WR_N) ? rd_hold_q : 16'bz;

    assign hpi.OTG_INT      = int_q;
    assign dev_mbx_in_valid = mbx_in_valid_q;
    assign dev_mbx_in_data  = mbx_in_q;
    assign proto_err        = proto_err_q;

endmodule
